// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus an any-edge detector.
// edge_pulse is high for one clk cycle per level change seen at the second flop.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_pulse
);

    logic s1_q;
    logic s2_q;
    logic s_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            s1_q     <= d;
            s2_q     <= s1_q;
            s_prev_q <= s2_q;
        end
    end

    // Rising and falling edges count alike.
    assign edge_pulse = s2_q ^ s_prev_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures clk cycles between consecutive edges of an asynchronous square wave.
// period/valid register two cycles after the synchronizer's second stage sees the edge.
module toggle_period_meter #(
    parameter int unsigned COUNT_WIDTH   = 25,
    parameter int unsigned TIMEOUT_COUNT = 12000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   valid,
    output logic                   stalled
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_COUNT - 1);

    state_e                 state_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [COUNT_WIDTH-1:0] period_q;
    logic                   valid_q;
    logic                   stalled_q;
    logic                   edge_det;

    edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .d          (sig_in),
        .edge_pulse (edge_det)
    );

    // The timeout keeps count_q below TIMEOUT_COUNT, so this never wraps.
    assign count_d = count_q + COUNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // First edge only arms; stalled stays up until a full measurement.
                    if (edge_det) begin
                        count_q <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        period_q  <= count_d;
                        valid_q   <= 1'b1;
                        count_q   <= '0;
                        stalled_q <= 1'b0;
                    end else if (count_q == TIMEOUT_LAST) begin
                        stalled_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        count_q <= count_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign stalled = stalled_q;

endmodule

// File: doc/toggle_period_meter.md
# toggle_period_meter

Measures the period of an externally toggling square wave, such as the output of the team's clock divider or an off-board oscillator, in units of `clk` cycles. It synchronizes the asynchronous input, detects every edge, and reports the cycle count between consecutive edges with a one-cycle valid strobe. It also flags a stalled input via timeout. It sits on the receive side of a divided-clock link, feeding LED/UART debug logic or a self-check in the bench.

## Interface
Parameters:
- `COUNT_WIDTH`, 25: width of the internal counter and of `period`.
- `TIMEOUT_COUNT`, 12000000: count value, with no edge seen, at which the input is declared stalled. Must be ≥ 2 and ≤ 2^COUNT_WIDTH − 1.

Ports:
- `clk`  input  1: system clock.
- `rst`  input  1: reset, asynchronous, active-high. The clock is `clk`.
- `sig_in`  input  1: measured signal, asynchronous to `clk`.
- `period`  output  COUNT_WIDTH: last measured edge-to-edge interval in `clk` cycles.
- `valid`  output  1: one-cycle pulse when `period` is updated.
- `stalled`  output  1: level; high while no edge has been seen within `TIMEOUT_COUNT` cycles.

## Operation
- **Synchronizer:** `sig_in` passes through 2 flops (`s1`, `s2`). A third flop, `s_prev`, holds the previous `s2`. `edge = s2 ^ s_prev`, so rising and falling edges are treated alike.
- **FSM states:**
  - **IDLE:** no reference edge held.
    - On `edge`: `count <= 0`, go to MEASURE. `valid` stays low, because the first edge only arms the measurement.
  - **MEASURE:**
    - Each cycle without an edge: `count <= count + 1`.
    - On `edge`: `period <= count + 1`, `valid <= 1`, `count <= 0`, `stalled <= 0`, remain in MEASURE.
    - If `count == TIMEOUT_COUNT − 1` with no edge that cycle: `stalled <= 1`, go to IDLE. `period` is held and `valid` stays low.
- **Reported value:** `period` equals the number of `clk` cycles between the two detected edges. For a clock divider toggling every N clk cycles, `period == N`.
- **Edge on the timeout cycle:** an edge wins. The measurement completes and no stall is flagged.
- **Arithmetic:** `count + 1` is computed at COUNT_WIDTH bits. The timeout guarantees the counter never wraps.
- **`stalled` after a stall:** stays high through IDLE. It clears only on the next completed measurement (the second edge after the stall), not on the arming edge.
- **Reset values (asynchronous, immediate on `rst`):**
  - FSM → IDLE
  - `count` = 0
  - `period` = 0
  - `valid` = 0
  - `stalled` = 0
  - `s1`, `s2`, `s_prev` = 0
- **Reset mid-measurement:** the partial count is discarded. After reset, two edges are required before `valid`.

## Timing
- **Edge latency:** `clk` edge k samples the new `sig_in` level into `s1`, `s2` updates at k+1, and `edge` is high during the cycle after k+1. `period` and `valid` register at edge k+2.
- **`valid`:** high for exactly one cycle per completed measurement, and never on two consecutive cycles unless edges are 1 cycle apart.
- **Minimum resolvable interval:** 1 cycle, which requires `sig_in` stable ≥ 1 clk between toggles. Faster inputs alias; this is out of scope.
- **Stall timing:** `stalled` rises `TIMEOUT_COUNT` cycles after the last detected edge.
- **Outputs:** all outputs are registered. There are no combinational paths from `sig_in`.

## Structure
- State encoding is `localparam` inside the module (2 states). No shared package is needed, because nothing is exported to other blocks.
- One sub-module, `edge_sync`: a 2-flop synchronizer plus any-edge detector. Inputs are `clk`, `rst`, `d`; output is the `edge` pulse. It is reusable for buttons and other asynchronous inputs.
- Top level is the FSM, counter, and output registers.

## Test plan
All scenarios use `COUNT_WIDTH`=25, `TIMEOUT_COUNT`=100 unless noted.
1. Toggle `sig_in` every 12 clk cycles for 10 toggles → first `valid` after the second edge. Every `valid` carries `period`=12, with 9 pulses total, each 1 cycle wide, and `stalled`=0.
2. Drive from a clock divider instance with MAX_COUNT=5 → `period`=6 on every `valid`.
3. Toggle once, then hold `sig_in` for 150 cycles → `stalled` rises 100 cycles after the detected edge, `valid` never pulses, and `period` stays 0.
4. After a stall, toggle every 20 cycles → no `valid` on the first edge, `period`=20 on the second edge, and `stalled` drops in the same cycle `valid` rises.
5. Assert `rst` for 3 cycles mid-measurement, 7 cycles after an edge → all outputs 0 during reset. The next two edges, 30 cycles apart, give `period`=30.
6. Set `TIMEOUT_COUNT`=50 and place an edge exactly 50 cycles after the previous one → `valid` with `period`=50, and `stalled` stays 0.
